instr_prefetch: RTL
===================

INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DEPTH, default 4: prefetch FIFO entries (power of two, >=2).
REQ-002 Parameter AW, default 5: byte-address width of instruction memory (32 bytes).
REQ-003 Parameter RESET_PC, default 32'h0: fetch address after reset.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 redirect_valid  in  1  core requests a fetch restart (taken branch, jump, jr).
REQ-007 redirect_pc  in  32  new fetch byte address; sampled when redirect_valid=1.
REQ-008 imem_addr  out  AW  byte address to the instruction memory, combinational from state.
REQ-009 imem_rdata  in  8  byte at imem_addr, same-cycle (asynchronous) read.
REQ-010 out_valid  out  1  FIFO head holds a complete instruction.
REQ-011 out_instr  out  32  head instruction, big-endian assembled.
REQ-012 out_pc  out  32  byte address of the head instruction.
REQ-013 out_ready  in  1  core consumes head; pop occurs when out_valid & out_ready.

Function
REQ-014 The FSM SHALL have states FILL (assembling bytes, byte counter cnt 0..3) and HOLD (word complete, FIFO full).
REQ-015 In FILL, imem_addr SHALL equal (fetch_pc[AW-1:0] + cnt) mod 2^AW; in HOLD it SHALL hold the last byte address.
REQ-016 Bytes SHALL be placed big-endian: cnt 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
REQ-017 At cnt=3 with a free slot (count<DEPTH, or a pop in the same cycle) the block SHALL push {word, fetch_pc}, set fetch_pc += 4 (32-bit wrap), cnt=0, stay in FILL.
REQ-018 At cnt=3 with FIFO full and no pop, the block SHALL capture byte 3, enter HOLD, and hold the word and fetch_pc unchanged.
REQ-019 In HOLD, the first cycle with a pop SHALL push the held word, advance fetch_pc by 4, and return to FILL with cnt=0.
REQ-020 Push-to-visibility latency SHALL be one cycle: pushed entry drives out_valid on the next cycle when FIFO was empty.
REQ-021 Steady-state throughput SHALL be one instruction per 4 cycles; first out_valid after reset release SHALL rise at the 5th rising edge.
REQ-022 Simultaneous push and pop on a full FIFO SHALL be legal and leave count unchanged.
REQ-023 redirect_valid SHALL take priority over all other events: FIFO cleared, partial word discarded, fetch_pc=redirect_pc, cnt=0, state FILL; any same-cycle pop is void.
REQ-024 The cycle after a redirect, imem_addr SHALL equal redirect_pc[AW-1:0]; misaligned redirect_pc SHALL be fetched as-is, bytes wrapping modulo 2^AW.
REQ-025 When out_valid=0, out_instr and out_pc SHALL be driven 0.
REQ-026 out_valid, out_instr, out_pc SHALL depend only on registered state (no combinational path from inputs).

Reset
REQ-027 On posedge clk with rst_n=0: fetch_pc=RESET_PC, cnt=0, state FILL, FIFO empty, out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC[AW-1:0].
REQ-028 Reset asserted mid-word or in HOLD SHALL discard all buffered data; reset SHALL override redirect_valid.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (FILL, HOLD) and the DEPTH/AW/RESET_PC default constants.
REQ-030 The FIFO SHALL be a sub-module instr_fifo (64-bit entries {pc, instr}, DEPTH entries, push/pop/clear, full/empty, count); assembly FSM stays in instr_prefetch.

Verification
REQ-031 Mem[0..7]=20 08 00 05 8C 09 00 04, RESET_PC=0, out_ready=1 -> edge 5: out_valid=1, out_instr=20080005, out_pc=0; 4 cycles later 8C090004, out_pc=4.
REQ-032 out_ready=0 for 40 cycles, DEPTH=4 -> exactly 4 entries then HOLD; imem_addr frozen; on release entries popped in order, pc 0,4,8,12,16 with no gaps or duplicates.
REQ-033 Redirect to 32'h10 during cnt=2 of the word at pc 8 -> next cycle out_valid=0, imem_addr=0x10; next pushed out_pc=0x10.
REQ-034 Redirect to 32'h1E (AW=5) -> bytes read at 0x1E,0x1F,0x00,0x01; out_pc=0x1E; following out_pc=0x22, imem_addr wraps to 0x02.
REQ-035 FIFO full with out_ready=1 at the cnt=3 cycle -> pop and push same cycle, count stays 4, no HOLD entry.
REQ-036 rst_n=0 for one cycle while in HOLD with redirect_valid=1 -> all outputs per REQ-027, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_pkg.sv
// rtl/instr_prefetch_pkg.sv - shared constants and FSM state type for the instruction prefetcher
// Contents: default DEPTH/AW/RESET_PC values and the assembly FSM state enum.
package instr_prefetch_pkg;

  localparam int          DEPTH_DEF    = 4;
  localparam int          AW_DEF       = 5;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;

  // FILL: assembling bytes of the word at fetch_pc.
  // HOLD: all four bytes captured, waiting for a FIFO slot.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pf_state_t;

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - prefetch FIFO of {pc, instr} entries with push/pop/clear
// Ports: clk, rst_n (sync, active-low), clear (flush), push/push_data, pop,
//        head_data (entry at read pointer), full, empty, count.
module instr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [63:0]                push_data,
  input  logic                       pop,
  output logic [63:0]                head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full      = (cnt_q == (PW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign head_data = mem[rd_ptr];

  // A pop frees the head slot at the same edge, so a push into a full FIFO is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - byte-wide instruction prefetcher assembling 32-bit words into a FIFO
// Ports: clk, rst_n (sync, active-low); redirect_valid/redirect_pc (fetch restart);
//        imem_addr/imem_rdata (async byte memory); out_valid/out_instr/out_pc/out_ready (head).
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH    = DEPTH_DEF,
  parameter int          AW       = AW_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [AW-1:0] imem_addr,
  input  logic [7:0]    imem_rdata,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  input  logic          out_ready
);

  pf_state_t              state;
  logic [31:0]            fetch_pc;
  logic [1:0]             cnt;
  logic [31:0]            word_q;

  logic                   pop;
  logic                   push;
  logic [63:0]            push_data;
  logic [63:0]            head_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   last_byte;
  logic                   slot_free;

  // cnt stays at 3 in HOLD, so the address naturally freezes on the last byte.
  assign imem_addr = fetch_pc[AW-1:0] + AW'(cnt);

  assign out_valid = (fifo_count != '0);
  assign out_instr = fifo_empty ? 32'h0 : head_data[31:0];
  assign out_pc    = fifo_empty ? 32'h0 : head_data[63:32];

  // A redirect voids any same-cycle pop and push; the FIFO is cleared instead.
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign slot_free = !fifo_full || pop;
  assign last_byte = (state == FILL) && (cnt == 2'd3);
  assign push      = !redirect_valid && ((last_byte && slot_free) || (state == HOLD && pop));
  assign push_data = (state == HOLD) ? {fetch_pc, word_q} : {fetch_pc, word_q[31:8], imem_rdata};

  instr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FILL;
      fetch_pc <= RESET_PC;
      cnt      <= 2'd0;
      word_q   <= 32'h0;
    end else if (redirect_valid) begin
      state    <= FILL;
      fetch_pc <= redirect_pc;
      cnt      <= 2'd0;
      word_q   <= 32'h0;
    end else begin
      case (state)
        FILL: begin
          case (cnt)
            2'd0:    word_q[31:24] <= imem_rdata;
            2'd1:    word_q[23:16] <= imem_rdata;
            2'd2:    word_q[15:8]  <= imem_rdata;
            default: word_q[7:0]   <= imem_rdata;
          endcase
          if (cnt != 2'd3) begin
            cnt <= cnt + 2'd1;
          end else if (slot_free) begin
            fetch_pc <= fetch_pc + 32'd4;
            cnt      <= 2'd0;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (pop) begin
            state    <= FILL;
            fetch_pc <= fetch_pc + 32'd4;
            cnt      <= 2'd0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
